// File: rtl/spi_baud_gen.sv
// rtl/spi_baud_gen.sv - SPI master baud-rate generator and transfer sequencer
// Divides clk by (SPPR+1)*2^SPR per half-period, clocks DATA_BITS bits, then holds a guard gap.
module spi_baud_gen #(
  parameter int DATA_BITS = 8,
  parameter int SPPR_W    = 3,
  parameter int SPR_W     = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SPPR_W-1:0]              SPPR,
  input  logic [SPR_W-1:0]               SPR,
  input  logic                           start,
  input  logic                           abort,
  output logic                           M_BaudRate,
  output logic                           idle,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(DATA_BITS+1)-1:0] bit_cnt
);

  localparam int HW  = SPPR_W + (1 << SPR_W);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int ECW = $clog2(2 * DATA_BITS + 1);
  localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SPPR_W-1:0] sppr_q, sppr_d;
  logic [SPR_W-1:0]  spr_q, spr_d;
  logic [HW-1:0]     presc_q, presc_d;
  logic [ECW-1:0]    edge_q, edge_d;
  logic [BCW-1:0]    bit_q, bit_d;
  logic              baud_q, baud_d;
  logic              done_q, done_d;

  logic [HW-1:0]     half_len;
  logic [HW-1:0]     half_m1;
  logic              presc_tc;

  // Half-period is taken from the shadow copy so mid-transfer register writes are harmless
  assign half_len = (HW'(sppr_q) + HW'(1)) << spr_q;
  assign half_m1  = half_len - HW'(1);
  assign presc_tc = (presc_q == half_m1);

  always_comb begin
    state_d = state_q;
    sppr_d  = sppr_q;
    spr_d   = spr_q;
    presc_d = presc_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      baud_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          baud_d = 1'b0;
          if (start) begin
            state_d = RUN;
            sppr_d  = SPPR;
            spr_d   = SPR;
            presc_d = '0;
            edge_d  = '0;
            bit_d   = '0;
          end
        end
        RUN: begin
          if (presc_tc) begin
            presc_d = '0;
            baud_d  = ~baud_q;
            edge_d  = edge_q + ECW'(1);
            if (baud_q) begin
              bit_d = bit_q + BCW'(1);
            end
            // Final toggle is a falling edge, so the baud line is already low entering GAP
            if (edge_q == LAST_EDGE) begin
              state_d = GAP;
            end
          end else begin
            presc_d = presc_q + HW'(1);
          end
        end
        GAP: begin
          if (presc_tc) begin
            presc_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            presc_d = presc_q + HW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          baud_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sppr_q  <= '0;
      spr_q   <= '0;
      presc_q <= '0;
      edge_q  <= '0;
      bit_q   <= '0;
      baud_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sppr_q  <= sppr_d;
      spr_q   <= spr_d;
      presc_q <= presc_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      done_q  <= done_d;
    end
  end

  assign M_BaudRate = baud_q;
  assign idle       = (state_q != RUN);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign bit_cnt    = bit_q;

endmodule

// File: tb/tb_spi_baud_gen.sv
// tb/tb_spi_baud_gen.sv - directed self-checking bench for spi_baud_gen
// Observation index t=1 is the cycle right after the edge that samples start.
module tb_spi_baud_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [2:0] sppr;
  logic [2:0] spr;
  logic       m_baud;
  logic       idle;
  logic       busy;
  logic       done;
  logic [3:0] bit_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_baud_gen #(
    .DATA_BITS(8),
    .SPPR_W   (3),
    .SPR_W    (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SPPR      (sppr),
    .SPR       (spr),
    .start     (start),
    .abort     (abort),
    .M_BaudRate(m_baud),
    .idle      (idle),
    .busy      (busy),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );

  // Expected {baud, idle, busy, done, bit_cnt} at index t for half-period h
  function automatic logic [7:0] exp_vec(input int h, input int t);
    int k;
    k = (t - 1) / h;
    if (t <= 16 * h) return {k[0], 1'b0, 1'b1, 1'b0, 4'(k / 2)};
    else if (t <= 17 * h) return {1'b0, 1'b1, 1'b1, 1'b0, 4'd8};
    else return {1'b0, 1'b1, 1'b0, 1'b1, 4'd8};
  endfunction

  function automatic logic [7:0] obs();
    return {m_baud, idle, busy, done, bit_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_transfer(input logic [2:0] p, input logic [2:0] r, input bit hold_start,
                              input int chg_at, input string name);
    int h;
    h = (int'(p) + 1) * (1 << r);
    sppr  = p;
    spr   = r;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    for (int t = 1; t <= 17 * h + 1; t++) begin
      if (t == chg_at) spr = 3'd0;
      checks++;
      if (obs() !== exp_vec(h, t)) begin
        errors++;
        $display("FAIL %s t=%0d actual=%b required=%b", name, t, obs(), exp_vec(h, t));
      end
      if (t < 17 * h + 1) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    sppr  = 3'd0;
    spr   = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs() !== 8'b0100_0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d actual=%b required=%b", i, obs(), 8'b0100_0000);
      end
    end
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (obs() !== 8'b0010_0000) begin
      errors++;
      $display("FAIL reset_release_start actual=%b required=%b", obs(), 8'b0010_0000);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs() !== 8'b0100_0000) begin
      errors++;
      $display("FAIL reset_cleanup actual=%b required=%b", obs(), 8'b0100_0000);
    end
  endtask

  task automatic test_basic();
    run_transfer(3'd0, 3'd0, 1'b0, 0, "h1");
  endtask

  task automatic test_h8_spr_change();
    run_transfer(3'd1, 3'd2, 1'b0, 40, "h8_sprchg");
  endtask

  task automatic test_back_to_back();
    run_transfer(3'd0, 3'd1, 1'b1, 0, "b2b_first");
    run_transfer(3'd0, 3'd1, 1'b1, 0, "b2b_second");
    start = 1'b0;
    tick();
    checks++;
    if (obs() !== 8'b0100_1000) begin
      errors++;
      $display("FAIL b2b_settle actual=%b required=%b", obs(), 8'b0100_1000);
    end
  endtask

  task automatic test_abort();
    int n;
    int dn;
    sppr  = 3'd0;
    spr   = 3'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (bit_cnt !== 4'd3 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL abort_wait_bit3 actual=%0d required=3", bit_cnt);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (obs() !== 8'b0100_0011) begin
      errors++;
      $display("FAIL abort_state actual=%b required=%b", obs(), 8'b0100_0011);
    end
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy || m_baud) dn++;
      tick();
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL abort_quiet activity_cycles=%0d required=0", dn);
    end
    run_transfer(3'd0, 3'd0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_start_abort_and_busy_start();
    int act;
    int dn;
    int done_t;
    sppr  = 3'd0;
    spr   = 3'd0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (obs() !== 8'b0100_1000) begin
      errors++;
      $display("FAIL start_abort_same actual=%b required=%b", obs(), 8'b0100_1000);
    end
    act = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_baud || busy || !idle) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL start_abort_quiet activity_cycles=%0d required=0", act);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    dn     = 0;
    done_t = 0;
    for (int t = 1; t <= 40; t++) begin
      if (done) begin
        dn++;
        done_t = t;
      end
      start = (t == 5) || (t == 12);
      tick();
    end
    start = 1'b0;
    checks++;
    if (dn !== 1) begin
      errors++;
      $display("FAIL busy_start_done_count actual=%0d required=1", dn);
    end
    checks++;
    if (done_t !== 18) begin
      errors++;
      $display("FAIL busy_start_done_time actual=%0d required=18", done_t);
    end
  endtask

  task automatic test_reset_mid();
    sppr  = 3'd0;
    spr   = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++;
    if (bit_cnt !== 4'd3) begin
      errors++;
      $display("FAIL reset_mid_pre actual=%0d required=3", bit_cnt);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (obs() !== 8'b0100_0000) begin
      errors++;
      $display("FAIL reset_mid actual=%b required=%b", obs(), 8'b0100_0000);
    end
    tick();
    checks++;
    if (obs() !== 8'b0100_0000) begin
      errors++;
      $display("FAIL reset_mid_after actual=%b required=%b", obs(), 8'b0100_0000);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_h8_spr_change();
    test_back_to_back();
    test_abort();
    test_start_abort_and_busy_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
